// File: rtl/ext_mem_burst_model.sv
// ext_mem_burst_model
//   Synthesizable external-memory model for the mem_req/mem_resp interface.
//   Commands are queued in an in-order FIFO and served one at a time by a
//   small FSM: reads return BEATS beats after RD_LATENCY cycles, writes take
//   BEATS byte-masked data beats. Optional LFSR backpressure on both readys.
// Ports
//   clk, reset (async, active-low)
//   mem_req_*      : command (valid/ready, rw, beat addr, tag) and write
//                    beats (data_valid/ready, bits, byte mask)
//   mem_resp_*     : registered read beats (valid, tag, data), no backpressure
// Storage is split into DATA_BITS/8 byte lanes, each its own array; it is never
// cleared by reset.

module ext_mem_byte_lane #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  // Read register holds its value between beats.
  always_ff @(posedge clk or negedge reset)
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[addr];
endmodule

module ext_mem_burst_model #(
  parameter int          DATA_BITS  = 128,
  parameter int          ADDR_BITS  = 28,
  parameter int          TAG_BITS   = 5,
  parameter int          DEPTH_LOG2 = 14,
  parameter int          BEATS      = 4,
  parameter int          CMD_DEPTH  = 4,
  parameter int          RD_LATENCY = 8,
  parameter int          STALL_EN   = 0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req_valid,
  output logic                   mem_req_ready,
  input  logic                   mem_req_rw,
  input  logic [ADDR_BITS-1:0]   mem_req_addr,
  input  logic [TAG_BITS-1:0]    mem_req_tag,
  input  logic                   mem_req_data_valid,
  output logic                   mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                   mem_resp_valid,
  output logic [TAG_BITS-1:0]    mem_resp_tag,
  output logic [DATA_BITS-1:0]   mem_resp_data
);
  localparam int NUM_LANES = DATA_BITS / 8;
  localparam int DL = DEPTH_LOG2;
  localparam int BL = $clog2(BEATS);
  localparam int BW = (BL == 0) ? 1 : BL;
  localparam int PL = $clog2(CMD_DEPTH);
  localparam int CW = PL + 1;
  localparam int LW = $clog2(RD_LATENCY) + 1;

  typedef struct packed {
    logic                rw;
    logic [DL-1:0]       addr;
    logic [TAG_BITS-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, RWAIT, RD, WR} state_t;

  state_t              state_q, state_d;
  cmd_t                fifo [CMD_DEPTH];
  logic [PL-1:0]       wp, rp;
  logic [CW-1:0]       cnt;
  logic [15:0]         lfsr;
  logic [LW-1:0]       lat_cnt;
  logic [BW-1:0]       bcnt;
  logic [DL-1:0]       cur_addr, beat_idx;
  logic [TAG_BITS-1:0] cur_tag;
  logic                full, empty, stall, enq, pop, rd_beat, wr_beat, last_beat;
  logic                unused_addr;

  logic [NUM_LANES-1:0][7:0] wr_bytes, rd_bytes;
  assign wr_bytes      = mem_req_data_bits;
  assign mem_resp_data = rd_bytes;

  // Storage wraps modulo depth; bits above DL are deliberately dropped.
  assign unused_addr = ^mem_req_addr;

  assign full  = (cnt == CW'(CMD_DEPTH));
  assign empty = (cnt == '0);
  assign stall = (STALL_EN != 0) && !lfsr[0];
  // Ready comes from registered occupancy only, so a dequeue from a full FIFO
  // cannot make room for an enqueue in the same cycle.
  assign mem_req_ready = reset & ~full & ~stall;
  assign enq           = mem_req_valid & mem_req_ready;

  // Base has its low bits cleared, so OR-ing the beat number walks the burst
  // without carrying into the upper address bits.
  assign beat_idx  = cur_addr | DL'(bcnt);
  assign last_beat = (bcnt == BW'(BEATS - 1));

  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d            = state_q;
    pop                = 1'b0;
    rd_beat            = 1'b0;
    wr_beat            = 1'b0;
    mem_req_data_ready = 1'b0;
    case (state_q)
      IDLE:  if (!empty) begin
               pop     = 1'b1;
               state_d = fifo[rp].rw ? WR : RWAIT;
             end
      RWAIT: if (lat_cnt == '0) state_d = RD;
      RD:    begin
               rd_beat = 1'b1;
               if (last_beat) state_d = IDLE;
             end
      WR:    begin
               mem_req_data_ready = ~stall;
               wr_beat            = mem_req_data_valid & ~stall;
               if (wr_beat && last_beat) state_d = IDLE;
             end
      default: state_d = IDLE;
    endcase
  end

  // FIFO payload needs no reset; occupancy is tracked by cnt.
  always_ff @(posedge clk)
    if (enq) fifo[wp] <= '{rw:   mem_req_rw,
                           addr: mem_req_addr[DL-1:0] & ~DL'(BEATS - 1),
                           tag:  mem_req_tag};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp             <= '0;
      rp             <= '0;
      cnt            <= '0;
      lfsr           <= LFSR_SEED;
      lat_cnt        <= '0;
      bcnt           <= '0;
      cur_addr       <= '0;
      cur_tag        <= '0;
      mem_resp_valid <= 1'b0;
      mem_resp_tag   <= '0;
    end else begin
      // x^16 + x^14 + x^13 + x^11
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (enq) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      case ({enq, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
      if (pop) begin
        cur_addr <= fifo[rp].addr;
        cur_tag  <= fifo[rp].tag;
        lat_cnt  <= LW'(RD_LATENCY - 1);
        bcnt     <= '0;
      end else begin
        if (state_q == RWAIT && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
        if (rd_beat || wr_beat)                bcnt    <= bcnt + 1'b1;
      end
      mem_resp_valid <= rd_beat;
      if (rd_beat) mem_resp_tag <= cur_tag;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    ext_mem_byte_lane #(.AW(DL)) u_lane (
      .clk   (clk),
      .reset (reset),
      .we    (wr_beat & mem_req_data_mask[i]),
      .re    (rd_beat),
      .addr  (beat_idx),
      .wdata (wr_bytes[i]),
      .rdata (rd_bytes[i])
    );
  end

  a_cnt_bound: assert property (@(posedge clk) disable iff (!reset) cnt <= CW'(CMD_DEPTH));
endmodule

// File: tb/tb_ext_mem_burst_model.sv
module tb_ext_mem_burst_model;
  localparam int DB = 128, AB = 28, TB = 5, DL = 10, NB = 16;

  logic clk = 0, reset = 0, sel = 0, hold = 0;
  always #5 clk = ~clk;

  logic          q_valid = 0, q_rw = 0, d_valid = 0;
  logic [AB-1:0] q_addr = '0;
  logic [TB-1:0] q_tag = '0;
  logic [DB-1:0] d_bits = '0;
  logic [NB-1:0] d_mask = '0;
  logic          rdy0, rdy1, drdy0, drdy1, rv0, rv1;
  logic [TB-1:0] rt0, rt1;
  logic [DB-1:0] rd0, rd1;
  logic          q_ready, d_ready, r_valid;
  logic [TB-1:0] r_tag;
  logic [DB-1:0] r_data;
  assign q_ready = sel ? rdy1 : rdy0;
  assign d_ready = sel ? drdy1 : drdy0;
  assign r_valid = sel ? rv1 : rv0;
  assign r_tag   = sel ? rt1 : rt0;
  assign r_data  = sel ? rd1 : rd0;

  ext_mem_burst_model #(.DEPTH_LOG2(DL)) u_dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(q_valid & ~sel), .mem_req_ready(rdy0), .mem_req_rw(q_rw),
    .mem_req_addr(q_addr), .mem_req_tag(q_tag),
    .mem_req_data_valid(d_valid & ~sel), .mem_req_data_ready(drdy0),
    .mem_req_data_bits(d_bits), .mem_req_data_mask(d_mask),
    .mem_resp_valid(rv0), .mem_resp_tag(rt0), .mem_resp_data(rd0));

  ext_mem_burst_model #(.DEPTH_LOG2(DL), .STALL_EN(1), .LFSR_SEED(16'hACE1)) u_dut_stall (
    .clk(clk), .reset(reset),
    .mem_req_valid(q_valid & sel), .mem_req_ready(rdy1), .mem_req_rw(q_rw),
    .mem_req_addr(q_addr), .mem_req_tag(q_tag),
    .mem_req_data_valid(d_valid & sel), .mem_req_data_ready(drdy1),
    .mem_req_data_bits(d_bits), .mem_req_data_mask(d_mask),
    .mem_resp_valid(rv1), .mem_resp_tag(rt1), .mem_resp_data(rd1));

  typedef struct {logic [TB-1:0] tag; logic [DB-1:0] data; bit first;} exp_t;
  typedef struct {logic [DB-1:0] data; logic [NB-1:0] mask;} wb_t;
  exp_t          exp_q[$];
  wb_t           wq[$];
  logic [DB-1:0] mdl [int];
  logic [DB-1:0] wd [4];
  logic [NB-1:0] wm [4];
  logic [DB-1:0] first_data;
  int n_err = 0, n_chk = 0, cyc = 0;
  int acc_edge, last_w_edge, first_cyc, beats_seen = 0, rdy_lo = 0, rdy_hi = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tg, input logic [DB-1:0] got, input logic [DB-1:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tg, got, want);
    end
  endtask

  function automatic int key(input logic [AB-1:0] a, input int b);
    return (int'(sel) << 16) | int'((a[DL-1:0] & ~10'h3) | 10'(b));
  endfunction

  function automatic logic [DB-1:0] merge(input logic [DB-1:0] old, input logic [DB-1:0] nw,
                                          input logic [NB-1:0] m);
    logic [DB-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++) if (m[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [DB-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Issue one command; scoreboard/model are updated in acceptance order.
  task automatic send(input bit rw, input logic [AB-1:0] a, input logic [TB-1:0] t);
    int n;
    n = 0;
    @(negedge clk);
    q_valid = 1; q_rw = rw; q_addr = a; q_tag = t;
    while (!q_ready && n < 3000) begin @(negedge clk); n++; end
    if (!q_ready) begin chk("req_accept_timeout", 0, 1); q_valid = 0; return; end
    acc_edge = cyc + 1;
    for (int b = 0; b < 4; b++) begin
      int k;
      k = key(a, b);
      if (rw) begin
        mdl[k] = merge(mdl.exists(k) ? mdl[k] : '0, wd[b], wm[b]);
        wq.push_back('{data: wd[b], mask: wm[b]});
      end else
        exp_q.push_back('{tag: t, data: (mdl.exists(k) ? mdl[k] : '0), first: (b == 0)});
    end
    @(posedge clk);
    #1 q_valid = 0;
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wq.size() != 0) && n < lim) begin @(negedge clk); n++; end
    chk("drain_pending", exp_q.size() + wq.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  // Write-beat driver: presents queued beats, pops on handshake.
  initial forever begin
    @(negedge clk);
    if (!hold && wq.size() > 0) begin
      d_valid = 1; d_bits = wq[0].data; d_mask = wq[0].mask;
    end else d_valid = 0;
    if (d_valid && d_ready) begin
      last_w_edge = cyc + 1;
      @(posedge clk);
      wq.delete(0);
    end
  end

  // Response monitor.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (sel && reset) begin
      if (q_ready) rdy_hi++; else rdy_lo++;
    end
    if (reset && r_valid) begin
      if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("resp_tag", r_tag, e.tag);
        chk("resp_data", r_data, e.data);
        if (e.first) begin first_cyc = cyc; first_data = r_data; end
      end
      beats_seen++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, base, n;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", rv0, 0);
    chk("rst_resp_tag", rt0, 0);
    chk("rst_resp_data", rd0, 0);
    chk("rst_req_ready", rdy0, 0);
    chk("rst_req_ready_stall", rdy1, 0);
    chk("rst_data_ready", drdy0, 0);
    reset = 1;
    repeat (2) @(negedge clk);
    chk("ready_after_rst", rdy0, 1);

    // Preload 0x40..0x43, then read 0x41 with tag 3.
    wd[0] = {4{32'hAAAA_0000}}; wd[1] = {4{32'hBBBB_1111}};
    wd[2] = {4{32'hCCCC_2222}}; wd[3] = {4{32'hDDDD_3333}};
    for (int b = 0; b < 4; b++) wm[b] = '1;
    send(1, 'h40, 0); drain(200);
    send(0, 'h41, 3); a1 = acc_edge; drain(200);
    chk("rd_latency", first_cyc - a1, 10);
    chk("rd_first_beat", first_data, {4{32'hAAAA_0000}});

    // Masked write over zeros.
    for (int b = 0; b < 4; b++) begin wd[b] = '0; wm[b] = '1; end
    send(1, 'h10, 0); drain(200);
    for (int b = 0; b < 4; b++) begin wd[b] = '1; wm[b] = '0; end
    wm[0] = 16'h00FF;
    send(1, 'h10, 0); send(0, 'h10, 1); drain(200);
    chk("masked_beat0", first_data, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF});

    // FIFO full: write stuck waiting for data, four reads fill the queue.
    hold = 1;
    for (int b = 0; b < 4; b++) begin wd[b] = rnd128(); wm[b] = '1; end
    send(1, 'h30, 0);
    for (int t = 0; t < 4; t++) send(0, 'h30, TB'(t));
    repeat (3) begin @(negedge clk); chk("full_ready", q_ready, 0); end
    hold = 0;
    send(0, 'h30, 4);
    chk("enq_after_pop_gap", acc_edge - last_w_edge, 2);
    send(0, 'h30, 5);
    drain(400);

    // Write then read queued back-to-back.
    for (int b = 0; b < 4; b++) begin wd[b] = rnd128(); wm[b] = '1; end
    send(1, 'h20, 0); send(0, 'h20, 9); drain(200);

    // Address aliasing: high bits dropped, low beat bits ignored.
    for (int b = 0; b < 4; b++) begin wd[b] = rnd128(); wm[b] = '1; end
    send(1, 'h60, 0); send(0, 28'hFFF_FC63, 10); send(0, 'h462, 11); drain(300);

    // Reset during the third read beat.
    for (int b = 0; b < 4; b++) begin wd[b] = rnd128(); wm[b] = '1; end
    send(1, 'h80, 0); drain(200);
    send(0, 'h80, 7);
    base = beats_seen; n = 0;
    while (beats_seen != base + 2 && n < 100) begin @(posedge clk); n++; end
    if (n >= 100) chk("beat2_timeout", 0, 1);
    #1 chk("beat2_valid_pre", r_valid, 1);
    reset = 0;
    #1 chk("rst_mid_valid", r_valid, 0);
    chk("rst_mid_ready", q_ready, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1;
    send(0, 'h80, 8); drain(200);

    // Random traffic on the backpressured instance.
    sel = 1;
    for (int i = 0; i < 16; i++) begin
      for (int b = 0; b < 4; b++) begin wd[b] = rnd128(); wm[b] = '1; end
      send(1, AB'('h200 + i * 4), 0);
    end
    for (int i = 0; i < 100; i++) begin
      for (int b = 0; b < 4; b++) begin wd[b] = rnd128(); wm[b] = NB'($urandom()); end
      send(1'($urandom_range(0, 1)), AB'('h200 + $urandom_range(0, 63)), TB'($urandom_range(0, 31)));
    end
    drain(20000);
    chk("ready_toggles", (rdy_lo > 0 && rdy_hi > 0), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
